// File: rtl/noc_traffic_sequencer.sv
// Stimulus sequencer: issues per-node send_start pulses in walk, broadcast or
// LFSR-random order, paced by a programmable interval and gated on node_ready.
module noc_traffic_sequencer #(
  parameter int unsigned NODE_NUM   = 16,
  parameter int unsigned INTERVAL_W = 16,
  parameter int unsigned COUNT_W    = 16,
  parameter logic [31:0] LFSR_SEED  = 32'hACE1_2024
) (
  input  logic                  noc_clk,
  input  logic                  noc_rst_n,
  input  logic [1:0]            cfg_mode,
  input  logic [INTERVAL_W-1:0] cfg_interval,
  input  logic [COUNT_W-1:0]    cfg_rounds,
  input  logic [4:0]            cfg_start_node,
  input  logic                  start,
  input  logic                  stop,
  input  logic [NODE_NUM-1:0]   node_ready,
  output logic [NODE_NUM-1:0]   send_start,
  output logic                  busy,
  output logic                  done,
  output logic [COUNT_W-1:0]    issued_cnt,
  output logic [COUNT_W-1:0]    stall_cnt
);

  localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;
  localparam logic [31:0] LFSR_INIT  = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;
  localparam logic [1:0]  MODE_BCAST = 2'd1;
  localparam logic [1:0]  MODE_RAND  = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ISSUE, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [1:0]            mode_q, mode_d;
  logic [INTERVAL_W-1:0] interval_q, interval_d;
  logic [COUNT_W-1:0]    rounds_q, rounds_d;
  logic [INTERVAL_W-1:0] wait_q, wait_d;
  logic [NODE_NUM-1:0]   mask_q, mask_d;
  logic [31:0]           lfsr_q, lfsr_d;
  logic [COUNT_W-1:0]    issued_d, stall_d;
  logic                  busy_d, done_d;
  logic                  blocked;

  // Random-mode mask: low LFSR bits, never allowed to be empty
  function automatic logic [NODE_NUM-1:0] rand_mask(input logic [NODE_NUM-1:0] low);
    rand_mask = (low == '0) ? NODE_NUM'(1) : low;
  endfunction

  // Galois right-shift LFSR step
  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    lfsr_step = {1'b0, x[31:1]} ^ (x[0] ? LFSR_TAPS : 32'h0);
  endfunction

  // Mask loaded when a run starts
  function automatic logic [NODE_NUM-1:0] init_mask(input logic [1:0] mode,
                                                   input logic [4:0] node,
                                                   input logic [NODE_NUM-1:0] low);
    if (mode == MODE_BCAST)     init_mask = '1;
    else if (mode == MODE_RAND) init_mask = rand_mask(low);
    else if (32'(node) < NODE_NUM) init_mask = NODE_NUM'(1) << node;
    else                        init_mask = NODE_NUM'(1);
  endfunction

  // Next-state, datapath updates and the combinational send_start pulse
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    interval_d = interval_q;
    rounds_d   = rounds_q;
    wait_d     = wait_q;
    mask_d     = mask_q;
    lfsr_d     = lfsr_q;
    issued_d   = issued_cnt;
    stall_d    = stall_cnt;
    send_start = '0;
    blocked    = |(mask_q & ~node_ready);

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          mode_d     = cfg_mode;
          interval_d = cfg_interval;
          rounds_d   = cfg_rounds;
          issued_d   = '0;
          stall_d    = '0;
          mask_d     = init_mask(cfg_mode, cfg_start_node, lfsr_q[NODE_NUM-1:0]);
          if (cfg_rounds == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT;
            wait_d  = cfg_interval;
          end
        end
      end
      S_WAIT: begin
        if (stop)               state_d = S_IDLE;
        else if (wait_q == '0)  state_d = S_ISSUE;
        else                    wait_d  = wait_q - INTERVAL_W'(1);
      end
      S_ISSUE: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (blocked) begin
          if (stall_cnt != '1) stall_d = stall_cnt + COUNT_W'(1);
        end else begin
          send_start = mask_q;
          issued_d   = issued_cnt + COUNT_W'(1);
          if (issued_d == rounds_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT;
            wait_d  = interval_q;
            if (mode_q == MODE_BCAST) begin
              mask_d = mask_q;
            end else if (mode_q == MODE_RAND) begin
              lfsr_d = lfsr_step(lfsr_q);
              mask_d = rand_mask(lfsr_d[NODE_NUM-1:0]);
            end else begin
              mask_d = {mask_q[NODE_NUM-2:0], mask_q[NODE_NUM-1]};
            end
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      state_q    <= S_IDLE;
      mode_q     <= '0;
      interval_q <= '0;
      rounds_q   <= '0;
      wait_q     <= '0;
      mask_q     <= '0;
      lfsr_q     <= LFSR_INIT;
      issued_cnt <= '0;
      stall_cnt  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      interval_q <= interval_d;
      rounds_q   <= rounds_d;
      wait_q     <= wait_d;
      mask_q     <= mask_d;
      lfsr_q     <= lfsr_d;
      issued_cnt <= issued_d;
      stall_cnt  <= stall_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

endmodule

// File: tb/tb_noc_traffic_sequencer.sv
// Self-checking bench for noc_traffic_sequencer against a run-level reference model.
`timescale 1ns/1ps
module tb_noc_traffic_sequencer;

  localparam int unsigned N  = 16;
  localparam int unsigned IW = 16;
  localparam int unsigned CW = 16;
  localparam logic [31:0] SEED = 32'hACE1_2024;
  localparam logic [31:0] TAPS = 32'h8020_0003;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    cfg_mode = '0;
  logic [IW-1:0] cfg_interval = '0;
  logic [CW-1:0] cfg_rounds = '0;
  logic [4:0]    cfg_start_node = '0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [N-1:0]  node_ready = '1;
  logic [N-1:0]  send_start;
  logic          busy, done;
  logic [CW-1:0] issued_cnt, stall_cnt;

  int errors = 0;
  int checks = 0;
  logic [31:0] m_lfsr = SEED;

  noc_traffic_sequencer #(
    .NODE_NUM(N), .INTERVAL_W(IW), .COUNT_W(CW), .LFSR_SEED(SEED)
  ) dut (
    .noc_clk(clk), .noc_rst_n(rst_n),
    .cfg_mode(cfg_mode), .cfg_interval(cfg_interval), .cfg_rounds(cfg_rounds),
    .cfg_start_node(cfg_start_node), .start(start), .stop(stop),
    .node_ready(node_ready), .send_start(send_start), .busy(busy), .done(done),
    .issued_cnt(issued_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Reference LFSR: shift right, fold the taps back in when a 1 falls out
  function automatic logic [31:0] lfsr_next(input logic [31:0] x);
    lfsr_next = (x / 2) ^ (((x % 2) == 1) ? TAPS : 32'h0);
  endfunction

  function automatic logic [N-1:0] model_rand_mask();
    logic [N-1:0] r;
    r = N'(m_lfsr);
    model_rand_mask = (r == '0) ? N'(1) : r;
  endfunction

  // One complete run checked cycle by cycle; caller leaves us just after a rising edge, DUT idle.
  // stall_hold: keep node 2 not-ready for that many ISSUE cycles before the first pulse.
  // stop_at: sample index at which stop is raised (-1 = never).
  task automatic run_seq(input string tag, input logic [1:0] mode, input int interval,
                         input int rounds, input int snode, input int ready_pct,
                         input int stall_hold, input int stop_at);
    logic [N-1:0] m, ready, exp_send;
    logic exp_busy, exp_done;
    int pulses, stalls, elig, k, phase;
    bit fin;
    if (mode == 2'd1)      m = '1;
    else if (mode == 2'd2) m = model_rand_mask();
    else                   m = (snode < int'(N)) ? (N'(1) << snode) : N'(1);
    cfg_mode = mode; cfg_interval = IW'(interval); cfg_rounds = CW'(rounds);
    cfg_start_node = 5'(snode); stop = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cfg_mode = 2'($urandom); cfg_interval = IW'($urandom); cfg_rounds = CW'($urandom);
    cfg_start_node = 5'($urandom);
    pulses = 0; stalls = 0; k = 0; fin = 0;
    elig = interval + 1;
    phase = (rounds == 0) ? 1 : 0;
    while (!fin) begin
      if (phase == 0 && pulses == 0 && k < interval + 1 + stall_hold)
        ready = ~(N'(1) << 2);
      else if (int'($urandom_range(99)) < ready_pct)
        ready = '1;
      else
        ready = ~(N'(1) << $urandom_range(N-1));
      node_ready = ready;
      stop  = (phase == 0 && k == stop_at);
      start = (phase == 2) ? 1'b0 : 1'($urandom_range(1));
      @(negedge clk);
      exp_send = '0; exp_busy = 1'b1; exp_done = 1'b0;
      if (issued_cnt !== CW'(pulses)) begin
        errors++; $display("FAIL %s issued_cnt k=%0d got %0d want %0d", tag, k, issued_cnt, pulses);
      end
      checks++;
      if (stall_cnt !== CW'(stalls)) begin
        errors++; $display("FAIL %s stall_cnt k=%0d got %0d want %0d", tag, k, stall_cnt, stalls);
      end
      checks++;
      case (phase)
        0: begin
          if (k == stop_at) begin
            phase = 2;
          end else if (k >= elig) begin
            if ((m & ~ready) == '0) begin
              exp_send = m;
              pulses++;
              if (pulses == rounds) begin
                phase = 1;
              end else begin
                elig = k + interval + 2;
                if (mode == 2'd2) begin
                  m_lfsr = lfsr_next(m_lfsr);
                  m = model_rand_mask();
                end else if (mode != 2'd1) begin
                  m = (m << 1) | (m >> (N-1));
                end
              end
            end else if (stalls < 65535) begin
              stalls++;
            end
          end
        end
        1: begin exp_done = 1'b1; phase = 2; end
        default: begin exp_busy = 1'b0; fin = 1; end
      endcase
      if (send_start !== exp_send) begin
        errors++; $display("FAIL %s send_start k=%0d got %h want %h", tag, k, send_start, exp_send);
      end
      checks++;
      if (busy !== exp_busy) begin
        errors++; $display("FAIL %s busy k=%0d got %b want %b", tag, k, busy, exp_busy);
      end
      checks++;
      if (done !== exp_done) begin
        errors++; $display("FAIL %s done k=%0d got %b want %b", tag, k, done, exp_done);
      end
      checks++;
      k++;
      if (k > 5000 && !fin) begin
        errors++; checks++;
        $display("FAIL %s timeout got k=%0d want completion", tag, k);
        fin = 1;
      end
      @(posedge clk); #1;
    end
    stop = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    if ({send_start, busy, done, issued_cnt, stall_cnt} !== '0) begin
      errors++; $display("FAIL reset outputs got %h/%b/%b/%0d/%0d want all zero",
                         send_start, busy, done, issued_cnt, stall_cnt);
    end
    checks++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset idle busy got %b want 0", busy);
    end
    checks++;
  endtask

  task automatic test_walk();
    run_seq("walk", 2'd0, 3, 6, 2, 100, 0, -1);
    run_seq("walk_mode3", 2'd3, 1, 3, 7, 100, 0, -1);
  endtask

  task automatic test_broadcast_stall();
    run_seq("bcast_stall", 2'd1, 0, 3, 0, 100, 4, -1);
  endtask

  task automatic test_random();
    run_seq("random_run1", 2'd2, 1, 5, 0, 100, 0, -1);
    run_seq("random_run2", 2'd2, 0, 5, 0, 100, 0, -1);
  endtask

  task automatic test_rounds_zero();
    run_seq("rounds_zero", 2'd0, 4, 0, 3, 100, 0, -1);
  endtask

  task automatic test_stop();
    run_seq("stop_wait", 2'd0, 3, 8, 0, 100, 0, 11);
    run_seq("stop_issue", 2'd1, 1, 4, 0, 100, 6, 5);
    repeat (3) @(posedge clk);
    #1;
    if (issued_cnt !== CW'(0) || stall_cnt !== CW'(3)) begin
      errors++; $display("FAIL stop_hold counters got %0d/%0d want 0/3", issued_cnt, stall_cnt);
    end
    checks++;
  endtask

  task automatic test_edge_index();
    run_seq("edge_index", 2'd0, 0, 3, 20, 100, 0, -1);
    run_seq("wrap", 2'd0, 2, 4, 14, 100, 0, -1);
  endtask

  task automatic test_reset_midrun();
    node_ready = '1;
    cfg_mode = 2'd0; cfg_interval = IW'(2); cfg_rounds = CW'(10); cfg_start_node = 5'd5;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    if (send_start !== N'(16'h0020)) begin
      errors++; $display("FAIL midrun pulse got %h want %h", send_start, N'(16'h0020));
    end
    checks++;
    rst_n = 1'b0;
    #1;
    if ({send_start, busy, done, issued_cnt, stall_cnt} !== '0) begin
      errors++; $display("FAIL midrun reset got %h/%b/%b/%0d/%0d want all zero",
                         send_start, busy, done, issued_cnt, stall_cnt);
    end
    checks++;
    m_lfsr = SEED;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_seq("reseed", 2'd2, 0, 3, 0, 100, 0, -1);
  endtask

  task automatic test_random_mix();
    for (int i = 0; i < 10; i++) begin
      int r, itv;
      r   = int'($urandom_range(6));
      itv = int'($urandom_range(4));
      run_seq("mix", 2'($urandom), itv, r, int'($urandom_range(31)), 60, 0,
              ($urandom_range(2) == 0) ? int'($urandom_range(20)) : -1);
    end
  endtask

  initial begin
    test_reset();
    test_walk();
    test_broadcast_stall();
    test_random();
    test_rounds_zero();
    test_stop();
    test_edge_index();
    test_reset_midrun();
    test_random_mix();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/noc_traffic_sequencer.md
Name: noc_traffic_sequencer

Overview:
- Synthesizable, parametrised stimulus sequencer that drives per-node send_start pulses into the NoC test nodes.
- Supports walking one-hot, broadcast and pseudo-random (LFSR) node-selection modes.
- Programmable inter-pulse interval and round count; start/stop/done control.
- Each pulse is gated on per-node readiness, with stall accounting.
- Sits beside Noc_fabric in the mesh top and replaces fixed-delay stimulus.

Parameters:
- NODE_NUM, 16, number of nodes (send_start/node_ready width); legal range 2..32.
- INTERVAL_W, 16, width of cfg_interval and the wait counter.
- COUNT_W, 16, width of cfg_rounds, issued_cnt and stall_cnt.
- LFSR_SEED, 32'hACE1_2024, reset value of the random-mode LFSR; a value of 0 is replaced by 1.

Ports:
- noc_clk  in  1  clock.
- noc_rst_n  in  1  asynchronous active-low reset.
- cfg_mode  in  2  0=walk, 1=broadcast, 2=random, 3=treated as walk.
- cfg_interval  in  INTERVAL_W  wait cycles before each issue.
- cfg_rounds  in  COUNT_W  number of pulses to issue.
- cfg_start_node  in  5  initial one-hot position (walk mode).
- start  in  1  begin sequence; sampled in IDLE only.
- stop  in  1  synchronous abort.
- node_ready  in  NODE_NUM  per-node accept-ready.
- send_start  out  NODE_NUM  one-cycle pulse mask to nodes.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on normal completion.
- issued_cnt  out  COUNT_W  pulses issued in the current/last run.
- stall_cnt  out  COUNT_W  ISSUE cycles blocked by node_ready; saturating.

Behaviour:
- Reset (async assert, sync-to-clock release):
  - state=IDLE; send_start, busy, done, issued_cnt and stall_cnt all 0.
  - LFSR=LFSR_SEED (1 if the seed is 0); mask=0.
- Configuration latching:
  - All cfg_* inputs are latched at start acceptance.
  - Changes to cfg_* during a run have no effect on that run.
- FSM states: IDLE, WAIT, ISSUE, DONE.
- IDLE:
  - If start=1, latch cfg, clear issued_cnt and stall_cnt, and load the initial mask.
  - cfg_rounds==0: go to DONE with no pulses issued.
  - Otherwise: go to WAIT with wait_cnt=cfg_interval.
- Initial mask by mode:
  - walk: one-hot at cfg_start_node; an index >= NODE_NUM uses bit 0.
  - broadcast: all ones.
  - random: LFSR[NODE_NUM-1:0]; if that value is 0, use 1.
- WAIT: wait_cnt decrements each cycle. In the cycle wait_cnt==0, the next state is ISSUE. WAIT therefore lasts cfg_interval+1 cycles.
- ISSUE with (mask & ~node_ready)==0:
  - send_start=mask for exactly this cycle; send_start is combinational from state, mask and node_ready.
  - At the clock edge, issued_cnt increments.
  - If issued_cnt+1==cfg_rounds: go to DONE.
  - Otherwise: advance the mask and go to WAIT with wait_cnt=cfg_interval.
- ISSUE with any masked node not ready:
  - send_start=0, stay in ISSUE.
  - stall_cnt increments, saturating at all-ones.
- Mask advance:
  - walk: rotate left by 1; bit NODE_NUM-1 wraps to bit 0.
  - broadcast: unchanged.
  - random: LFSR steps once (Galois, taps 32'h8020_0003); new mask per the random rule above.
- LFSR persistence: the LFSR is not reseeded between runs; only reset reseeds it.
- DONE: done=1 for one cycle, then IDLE.
- Pulse timing: with no stalls, the first pulse occurs cfg_interval+2 cycles after the start-acceptance edge. Subsequent pulses are spaced cfg_interval+2 cycles apart.
- busy: 1 in WAIT, ISSUE and DONE; 0 in IDLE.
- stop:
  - Valid in WAIT or ISSUE; has priority over issue.
  - That cycle send_start=0; next state is IDLE with no done pulse.
  - issued_cnt and stall_cnt hold their values.
- start while busy: ignored. start and stop together in IDLE: start is ignored.
- Reset mid-run: returns to the reset values immediately; no done pulse.
- Output hold: issued_cnt and stall_cnt hold their values in IDLE until the next accepted start.

Test Plan:
- Walk, NODE_NUM=4, interval=3, rounds=6, start_node=2, node_ready all ones:
  - send_start sequence 0100, 1000, 0001, 0010, 0100, 1000, spaced 5 cycles apart.
  - First pulse 5 cycles after start; done 1 cycle after the 6th pulse; issued_cnt=6.
- Broadcast, interval=0, rounds=3, node_ready=4'b1011:
  - No pulse; stall_cnt increments each cycle.
  - Raise node_ready[2] after 4 cycles: send_start=1111 issued; stall_cnt=4; then 2 more pulses 2 cycles apart.
- Random, NODE_NUM=8, rounds=5: each send_start is nonzero and matches a reference LFSR model seeded with 32'hACE1_2024. A second run continues the sequence without reseeding.
- rounds=0: busy high 1 cycle; done pulse; send_start never asserted; issued_cnt=0.
- Mid-run control:
  - stop asserted during WAIT of round 3: busy=0 next cycle; no done; issued_cnt=2.
  - start during busy: ignored.
  - noc_rst_n low mid-run: outputs zero immediately.
- Edge index: cfg_start_node=20 with NODE_NUM=16 gives first pulse 0x0001. Wrap check: 0x8000 is followed by 0x0001.
